// File: rtl/peripheral_bus_master_pkg.sv
// Shared encodings for the peripheral bus initiator: FSM states, the
// peripheral index field position inside the Wishbone address, and the read
// value returned on a timed-out access.
package peripheral_bus_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    localparam int PIDX_MSB = 15;
    localparam int PIDX_LSB = 12;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/peripheral_bus_timeout.sv
// Stall counter for a peripheral access: cleared outside the access, counts
// busy cycles, flags expiry on the last allowed busy cycle (never if 0).
module peripheral_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int COUNTER_WIDTH  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [COUNTER_WIDTH-1:0] LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic [COUNTER_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

endmodule

// File: rtl/peripheral_bus_master.sv
// Wishbone classic slave to peripheral bus initiator: one access at a time,
// index decode to one-hot enables, busy stall with timeout, ack/err return.
module peripheral_bus_master
    import peripheral_bus_master_pkg::*;
#(
    parameter int PERIPHERAL_COUNT = 8,
    parameter int TIMEOUT_CYCLES   = 255,
    parameter int COUNTER_WIDTH    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wb_cyc_i,
    input  logic                        wb_stb_i,
    input  logic                        wb_we_i,
    input  logic [3:0]                  wb_sel_i,
    input  logic [23:0]                 wb_adr_i,
    input  logic [31:0]                 wb_dat_i,
    output logic                        wb_ack_o,
    output logic                        wb_err_o,
    output logic [31:0]                 wb_dat_o,
    output logic [PERIPHERAL_COUNT-1:0] peripheral_enable,
    output logic                        peripheralBus_we,
    output logic                        peripheralBus_oe,
    input  logic                        peripheralBus_busy,
    output logic [11:0]                 peripheralBus_address,
    output logic [3:0]                  peripheralBus_byteSelect,
    output logic [31:0]                 peripheralBus_dataWrite,
    input  logic [31:0]                 peripheralBus_dataRead
);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [11:0] adr_q, adr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdat_q, wdat_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] rdat_q, rdat_d;

    logic        req;
    logic        idx_ok;
    logic        expired;
    logic        unused_adr;

    assign unused_adr = ^wb_adr_i[23:16];

    assign req    = wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o;
    assign idx_ok = {1'b0, wb_adr_i[PIDX_MSB:PIDX_LSB]} < 5'(PERIPHERAL_COUNT);

    peripheral_bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .COUNTER_WIDTH  (COUNTER_WIDTH)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q != ST_ACCESS),
        .en_i      ((state_q == ST_ACCESS) && peripheralBus_busy),
        .expired_o (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping cyc wins over completion so an abandoned cycle never acks.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = idx_ok ? ST_ACCESS : ST_RESPOND;
                end
            end
            ST_ACCESS: begin
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (!peripheralBus_busy || expired) begin
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d  = idx_q;
        adr_d  = adr_q;
        sel_d  = sel_q;
        wdat_d = wdat_q;
        we_d   = we_q;
        err_d  = err_q;
        rdat_d = rdat_q;
        if (state_q == ST_IDLE && req) begin
            idx_d  = wb_adr_i[PIDX_MSB:PIDX_LSB];
            adr_d  = wb_adr_i[11:0];
            sel_d  = wb_sel_i;
            wdat_d = wb_dat_i;
            we_d   = wb_we_i;
            err_d  = !idx_ok;
            rdat_d = '0;
        end else if (state_q == ST_ACCESS && wb_cyc_i) begin
            if (!peripheralBus_busy) begin
                err_d  = 1'b0;
                rdat_d = we_q ? 32'h0 : peripheralBus_dataRead;
            end else if (expired) begin
                err_d  = 1'b1;
                rdat_d = we_q ? 32'h0 : TIMEOUT_RDATA;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            adr_q  <= '0;
            sel_q  <= '0;
            wdat_q <= '0;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
            rdat_q <= '0;
        end else begin
            idx_q  <= idx_d;
            adr_q  <= adr_d;
            sel_q  <= sel_d;
            wdat_q <= wdat_d;
            we_q   <= we_d;
            err_q  <= err_d;
            rdat_q <= rdat_d;
        end
    end

    // Outputs decode only registered state, so no wb_* input reaches the bus.
    always_comb begin
        peripheral_enable        = '0;
        peripheralBus_we         = 1'b0;
        peripheralBus_oe         = 1'b0;
        peripheralBus_address    = '0;
        peripheralBus_byteSelect = '0;
        peripheralBus_dataWrite  = '0;
        wb_ack_o                 = 1'b0;
        wb_err_o                 = 1'b0;
        wb_dat_o                 = '0;
        if (state_q == ST_ACCESS) begin
            for (int i = 0; i < PERIPHERAL_COUNT; i++) begin
                peripheral_enable[i] = (idx_q == 4'(i));
            end
            peripheralBus_we         = we_q;
            peripheralBus_oe         = !we_q;
            peripheralBus_address    = adr_q;
            peripheralBus_byteSelect = sel_q;
            peripheralBus_dataWrite  = we_q ? wdat_q : 32'h0;
        end else if (state_q == ST_RESPOND) begin
            wb_ack_o = !err_q;
            wb_err_o = err_q;
            wb_dat_o = rdat_q;
        end
    end

endmodule

// File: tb/tb_peripheral_bus_master.sv
// Directed scoreboard bench: a default-timeout instance and a short-timeout
// instance share stimulus; cyc/stb is steered to one of them at a time.
module tb_peripheral_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we, use_to;
    logic [3:0]  sel;
    logic [23:0] adr;
    logic [31:0] wdat;
    logic        busy;
    logic [31:0] prd;

    logic        ack1, err1, pwe1, poe1, ack2, err2, pwe2, poe2;
    logic [31:0] dat1, pdw1, dat2, pdw2;
    logic [7:0]  en1, en2;
    logic [11:0] pa1, pa2;
    logic [3:0]  ps1, ps2;

    logic        o_ack, o_err, o_we, o_oe;
    logic [31:0] o_dat, o_dw;
    logic [7:0]  o_en;
    logic [11:0] o_pa;
    logic [3:0]  o_ps;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] dat;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    peripheral_bus_master #(.PERIPHERAL_COUNT(8), .TIMEOUT_CYCLES(255), .COUNTER_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(cyc & ~use_to), .wb_stb_i(stb & ~use_to), .wb_we_i(we),
        .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_ack_o(ack1), .wb_err_o(err1), .wb_dat_o(dat1),
        .peripheral_enable(en1), .peripheralBus_we(pwe1), .peripheralBus_oe(poe1),
        .peripheralBus_busy(busy), .peripheralBus_address(pa1),
        .peripheralBus_byteSelect(ps1), .peripheralBus_dataWrite(pdw1),
        .peripheralBus_dataRead(prd)
    );

    peripheral_bus_master #(.PERIPHERAL_COUNT(8), .TIMEOUT_CYCLES(4), .COUNTER_WIDTH(8)) dut_to (
        .clk(clk), .rst(rst),
        .wb_cyc_i(cyc & use_to), .wb_stb_i(stb & use_to), .wb_we_i(we),
        .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_ack_o(ack2), .wb_err_o(err2), .wb_dat_o(dat2),
        .peripheral_enable(en2), .peripheralBus_we(pwe2), .peripheralBus_oe(poe2),
        .peripheralBus_busy(busy), .peripheralBus_address(pa2),
        .peripheralBus_byteSelect(ps2), .peripheralBus_dataWrite(pdw2),
        .peripheralBus_dataRead(prd)
    );

    assign o_ack = use_to ? ack2 : ack1;
    assign o_err = use_to ? err2 : err1;
    assign o_dat = use_to ? dat2 : dat1;
    assign o_en  = use_to ? en2  : en1;
    assign o_we  = use_to ? pwe2 : pwe1;
    assign o_oe  = use_to ? poe2 : poe1;
    assign o_pa  = use_to ? pa2  : pa1;
    assign o_ps  = use_to ? ps2  : ps1;
    assign o_dw  = use_to ? pdw2 : pdw1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One Wishbone access; busy is held for the first nbusy ACCESS cycles.
    task automatic run(input string tag, input logic w, input logic [23:0] a,
                       input logic [3:0] s, input logic [31:0] d, input int nbusy,
                       input logic [31:0] rd, input logic [7:0] e_en,
                       input logic e_ack, input logic e_err, input logic [31:0] e_dat,
                       input int e_lat, input int e_strobes);
        exp_t e, got;
        int   cyc_n, strobes;
        logic done;
        e.ack = e_ack; e.err = e_err; e.dat = e_dat; e.lat = e_lat;
        sbq.push_back(e);
        @(negedge clk);
        we = w; adr = a; sel = s; wdat = d; cyc = 1'b1; stb = 1'b1; busy = 1'b0; prd = '0;
        cyc_n = 0; strobes = 0; done = 1'b0;
        while (!done && cyc_n < 300) begin
            @(negedge clk);
            cyc_n++;
            if (o_ack || o_err) begin
                done = 1'b1;
            end else begin
                if (o_we || o_oe || (o_en != 8'h0)) strobes++;
                if (cyc_n == 1 && e_strobes > 0) begin
                    chk({tag, ".enable"}, 32'(o_en), 32'(e_en));
                    chk({tag, ".we_oe"}, {30'h0, o_we, o_oe}, {30'h0, w, ~w});
                    chk({tag, ".address"}, 32'(o_pa), 32'(a[11:0]));
                    chk({tag, ".bytesel"}, 32'(o_ps), 32'(s));
                    chk({tag, ".datawrite"}, o_dw, w ? d : 32'h0);
                end
                busy = (cyc_n <= nbusy);
                prd  = busy ? 32'hBAD0_BAD0 : rd;
            end
        end
        chk({tag, ".responded"}, 32'(done), 32'd1);
        got = sbq.pop_front();
        chk({tag, ".ack"}, 32'(o_ack), 32'(got.ack));
        chk({tag, ".err"}, 32'(o_err), 32'(got.err));
        chk({tag, ".rdata"}, o_dat, got.dat);
        chk({tag, ".latency"}, 32'(cyc_n), 32'(got.lat));
        chk({tag, ".strobe_cycles"}, 32'(strobes), 32'(e_strobes));
        chk({tag, ".resp_quiet"}, {20'h0, o_en, 2'b0, o_we, o_oe}, 32'h0);
        cyc = 1'b0; stb = 1'b0; busy = 1'b0; prd = '0;
        @(negedge clk);
        chk({tag, ".one_cycle"}, {30'h0, o_ack, o_err}, 32'h0);
        chk({tag, ".dat_idle"}, o_dat, 32'h0);
    endtask

    initial begin
        int   stray;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; use_to = 1'b0;
        sel = '0; adr = '0; wdat = '0; busy = 1'b0; prd = '0;
        #1;
        chk("reset.wb", {o_dat[30:0], o_ack}, 32'h0);
        chk("reset.err", 32'(o_err), 32'h0);
        chk("reset.bus", {18'h0, o_en, 4'h0, o_we, o_oe}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run("wr_basic", 1'b1, 24'h002004, 4'b1111, 32'hDEADBEEF, 0, 32'h0,
            8'b0000_0100, 1'b1, 1'b0, 32'h0, 2, 1);
        run("rd_basic", 1'b0, 24'h001008, 4'b0011, 32'h5555AAAA, 0, 32'h0000_1234,
            8'b0000_0010, 1'b1, 1'b0, 32'h0000_1234, 2, 1);
        run("rd_busy5", 1'b0, 24'h007010, 4'b1100, 32'h0, 5, 32'hCAFE_F00D,
            8'b1000_0000, 1'b1, 1'b0, 32'hCAFE_F00D, 7, 6);
        run("wr_busy2", 1'b1, 24'h000FFC, 4'b0001, 32'h0000_00A5, 2, 32'h1111_1111,
            8'b0000_0001, 1'b1, 1'b0, 32'h0, 4, 3);
        run("rd_unmap_c", 1'b0, 24'h00C000, 4'b1111, 32'h0, 0, 32'h7777_7777,
            8'h00, 1'b0, 1'b1, 32'h0, 1, 0);
        run("wr_unmap_8", 1'b1, 24'h008010, 4'b1111, 32'h1234_5678, 0, 32'h0,
            8'h00, 1'b0, 1'b1, 32'h0, 1, 0);

        use_to = 1'b1;
        run("rd_timeout", 1'b0, 24'h003000, 4'b1111, 32'h0, 1000, 32'h0,
            8'b0000_1000, 1'b0, 1'b1, 32'hFFFF_FFFF, 5, 4);
        use_to = 1'b0;

        // Reset asserted mid-stall must clear outputs without a clock edge.
        @(negedge clk);
        we = 1'b0; adr = 24'h005020; sel = 4'b1111; cyc = 1'b1; stb = 1'b1; busy = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid.in_access", {30'h0, o_oe, o_en[5]}, 32'h3);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid.bus", {18'h0, o_en, 4'h0, o_we, o_oe}, 32'h0);
        chk("rst_mid.wb", {29'h0, o_ack, o_err, |o_dat}, 32'h0);
        cyc = 1'b0; stb = 1'b0; busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (o_ack || o_err || o_oe) stray++;
        end
        chk("rst_mid.no_resp", 32'(stray), 32'h0);
        run("wr_after_rst", 1'b1, 24'h006100, 4'b0110, 32'h0BAD_F00D, 0, 32'h0,
            8'b0100_0000, 1'b1, 1'b0, 32'h0, 2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
